// File: rtl/ppi_host.sv
// Command sequencer for an 8255-style parallel peripheral: turns WRITE/READ/BSET/BCLR/RMW/POLL
// requests into single-cycle bus strobes with registered outputs and a one-cycle DONE pulse.
module ppi_host #(
  parameter logic [15:0] POLL_MAX = 16'd255
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       REQ,
  input  logic [2:0] OP,
  input  logic [1:0] ADDR,
  input  logic [7:0] WDATA,
  input  logic [7:0] MASK,
  output logic       BUSY,
  output logic [7:0] RDATA,
  output logic       DONE,
  output logic       ERR,
  output logic       PPI_CS,
  output logic       PPI_WR,
  output logic [1:0] PPI_A,
  output logic [7:0] PPI_DOUT,
  input  logic [7:0] PPI_DIN
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_GAP, S_WR, S_FIN} state_e;

  localparam logic [2:0] OP_WRITE = 3'd0;
  localparam logic [2:0] OP_READ  = 3'd1;
  localparam logic [2:0] OP_BSET  = 3'd2;
  localparam logic [2:0] OP_BCLR  = 3'd3;
  localparam logic [2:0] OP_RMW   = 3'd4;
  localparam logic [2:0] OP_POLL  = 3'd5;

  state_e      state, state_nxt;
  logic [2:0]  op_q;
  logic [1:0]  addr_q;
  logic [7:0]  wdata_q, mask_q;
  logic [15:0] cnt, cnt_nxt, cnt_inc;
  logic        cs_nxt, wr_nxt, err_nxt;
  logic [1:0]  a_nxt;
  logic [7:0]  dout_nxt;

  assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;

  // Bus outputs are computed for the state being entered and registered alongside it.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through the case can infer a latch.
    state_nxt = state;
    cnt_nxt   = cnt;
    cs_nxt    = 1'b0;
    wr_nxt    = 1'b0;
    a_nxt     = 2'd0;
    dout_nxt  = 8'h00;
    err_nxt   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (REQ) begin
          cnt_nxt = '0;
          case (OP)
            OP_WRITE: begin
              state_nxt = S_WR;
              cs_nxt    = 1'b1;
              wr_nxt    = 1'b1;
              a_nxt     = ADDR;
              dout_nxt  = WDATA;
            end
            OP_READ, OP_RMW, OP_POLL: begin
              state_nxt = S_RD;
              cs_nxt    = 1'b1;
              a_nxt     = ADDR;
            end
            OP_BSET, OP_BCLR: begin
              state_nxt = S_WR;
              cs_nxt    = 1'b1;
              wr_nxt    = 1'b1;
              a_nxt     = 2'd3;
              dout_nxt  = {4'b0000, WDATA[2:0], (OP == OP_BSET)};
            end
            default: begin
              state_nxt = S_FIN;
              err_nxt   = 1'b1;
            end
          endcase
        end
      end
      S_RD: begin
        if (op_q == OP_POLL) begin
          cnt_nxt = cnt_inc;
          if (((PPI_DIN ^ wdata_q) & mask_q) == 8'h00) begin
            state_nxt = S_FIN;
          end else if (cnt_inc >= POLL_MAX) begin
            state_nxt = S_FIN;
            err_nxt   = 1'b1;
          end else begin
            state_nxt = S_GAP;
          end
        end else if (op_q == OP_RMW) begin
          state_nxt = S_GAP;
        end else begin
          state_nxt = S_FIN;
        end
      end
      S_GAP: begin
        cs_nxt = 1'b1;
        a_nxt  = addr_q;
        if (op_q == OP_RMW) begin
          state_nxt = S_WR;
          wr_nxt    = 1'b1;
          dout_nxt  = (RDATA & ~mask_q) | (wdata_q & mask_q);
        end else begin
          state_nxt = S_RD;
        end
      end
      S_WR:    state_nxt = S_FIN;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (RESET) begin
      state    <= S_IDLE;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      ERR      <= 1'b0;
      RDATA    <= 8'h00;
      PPI_CS   <= 1'b0;
      PPI_WR   <= 1'b0;
      PPI_A    <= 2'd0;
      PPI_DOUT <= 8'h00;
      cnt      <= '0;
    end else begin
      state    <= state_nxt;
      BUSY     <= (state_nxt != S_IDLE);
      DONE     <= (state_nxt == S_FIN);
      ERR      <= err_nxt;
      PPI_CS   <= cs_nxt;
      PPI_WR   <= wr_nxt;
      PPI_A    <= a_nxt;
      PPI_DOUT <= dout_nxt;
      cnt      <= cnt_nxt;
      if (state == S_RD) RDATA <= PPI_DIN;
    end
  end

  // NOTE: operand registers are always loaded at acceptance before use, so they carry no reset.
  always_ff @(posedge CLK) begin
    if (state == S_IDLE && REQ) begin
      op_q    <= OP;
      addr_q  <= ADDR;
      wdata_q <= WDATA;
      mask_q  <= MASK;
    end
  end

endmodule

// File: tb/tb_ppi_host.sv
// Scoreboard bench for ppi_host: a driver pushes expected completions and write strobes computed
// from a register-level peripheral model; a negedge monitor pops and compares them.
module tb_ppi_host;

  localparam logic [15:0] PMAX = 16'd4;

  logic       CLK = 1'b0;
  logic       RESET, REQ;
  logic [2:0] OP;
  logic [1:0] ADDR;
  logic [7:0] WDATA, MASK;
  logic       BUSY, DONE, ERR, PPI_CS, PPI_WR;
  logic [7:0] RDATA, PPI_DOUT, PPI_DIN;
  logic [1:0] PPI_A;

  ppi_host #(.POLL_MAX(PMAX)) dut (
    .CLK(CLK), .RESET(RESET), .REQ(REQ), .OP(OP), .ADDR(ADDR), .WDATA(WDATA), .MASK(MASK),
    .BUSY(BUSY), .RDATA(RDATA), .DONE(DONE), .ERR(ERR),
    .PPI_CS(PPI_CS), .PPI_WR(PPI_WR), .PPI_A(PPI_A), .PPI_DOUT(PPI_DOUT), .PPI_DIN(PPI_DIN)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         done_at;
    bit         err;
    logic [7:0] rdata;
    int         nreads;
    logic [1:0] rd_addr;
  } exp_t;

  typedef struct {
    logic [1:0] a;
    logic [7:0] d;
  } wr_t;

  exp_t done_q[$];
  wr_t  wr_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int reads    = 0;
  bit prev_cs  = 0;
  bit after_done = 0;

  // Peripheral environment: four storage registers, plus an optional value change on one
  // register after a given number of read strobes (used to make POLL succeed mid-way).
  logic [7:0] periph [4];
  int         flip_left;
  logic [1:0] flip_addr;
  logic [7:0] flip_val;

  // Reference model state.
  logic [7:0] mregs [4];
  logic [7:0] m_rdata = 8'h00;

  assign PPI_DIN = (PPI_CS && !PPI_WR) ? periph[PPI_A] : 8'hEE;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(posedge CLK) begin
    if (!RESET && PPI_CS) begin
      if (PPI_WR) periph[PPI_A] <= PPI_DOUT;
      else if (flip_left > 0) begin
        flip_left <= flip_left - 1;
        if (flip_left == 1) periph[flip_addr] <= flip_val;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail(input string name, input string what);
    n_checks++;
    $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
  endtask

  // Monitor: compares bus strobes and completions against the scoreboard queues.
  always @(negedge CLK) begin
    if (RESET) begin
      reads      = 0;
      prev_cs    = 0;
      after_done = 0;
    end else begin
      if (after_done) check("busy_after_done", BUSY, 0);
      after_done = DONE;
      if (!DONE && ERR) check("err_without_done", ERR, 0);
      if (PPI_CS) begin
        check("strobe_gap", prev_cs, 0);
        if (PPI_WR) begin
          if (wr_q.size() == 0) fail("unexpected_write", $sformatf("got A=%0h D=%0h, expected no write", PPI_A, PPI_DOUT));
          else begin
            wr_t w;
            w = wr_q.pop_front();
            check("write_addr", PPI_A, w.a);
            check("write_data", PPI_DOUT, w.d);
          end
        end else begin
          reads++;
          if (done_q.size() == 0) fail("unexpected_read", $sformatf("got read A=%0h, expected no read", PPI_A));
          else check("read_addr", PPI_A, done_q[0].rd_addr);
        end
      end else begin
        check("idle_bus", {PPI_WR, PPI_A, PPI_DOUT}, 0);
      end
      prev_cs = PPI_CS;
      if (DONE) begin
        if (done_q.size() == 0) fail("unexpected_done", "got DONE, expected none");
        else begin
          exp_t e;
          e = done_q.pop_front();
          check("done_cycle", cyc, e.done_at);
          check("done_err", ERR, e.err);
          check("done_rdata", RDATA, e.rdata);
          check("done_nreads", reads, e.nreads);
          check("busy_at_done", BUSY, 1);
        end
        reads = 0;
      end else if (done_q.size() > 0 && cyc > done_q[0].done_at) begin
        fail("missing_done", $sformatf("got no DONE, expected at cycle %0d", done_q[0].done_at));
        void'(done_q.pop_front());
        reads = 0;
      end
    end
  end

  task automatic wait_idle();
    int n;
    @(negedge CLK);
    n = 0;
    while (BUSY && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (BUSY) fail("idle_timeout", "got BUSY=1 after 200 cycles, expected 0");
  endtask

  task automatic set_reg(input logic [1:0] a, input logic [7:0] v);
    wait_idle();
    periph[a] <= v;
    mregs[a] = v;
  endtask

  // Issue one command; the expected outcome follows from the op's rules on the model registers.
  task automatic issue(input logic [2:0] op, input logic [1:0] addr, input logic [7:0] wd,
                       input logic [7:0] mk, input int f, input logic [7:0] v1,
                       input bit hold, input bit abort);
    exp_t e;
    int acc, lat, nr;
    bit hit;
    logic [7:0] v, wv;
    wait_idle();
    flip_left <= (op == 3'd5) ? f : 0;
    flip_addr <= addr;
    flip_val  <= v1;
    OP = op; ADDR = addr; WDATA = wd; MASK = mk; REQ = 1'b1;
    @(posedge CLK);
    #1;
    acc = cyc;
    if (!hold) REQ = 1'b0;
    e.err = 0; e.nreads = 0; e.rd_addr = addr;
    case (op)
      3'd0: begin lat = 2; wr_q.push_back('{addr, wd}); mregs[addr] = wd; end
      3'd1: begin lat = 2; e.nreads = 1; m_rdata = mregs[addr]; end
      3'd2, 3'd3: begin
        lat = 2;
        wv = {4'b0000, wd[2:0], (op == 3'd2)};
        wr_q.push_back('{2'd3, wv});
        mregs[3] = wv;
      end
      3'd4: begin
        lat = 4; e.nreads = 1; m_rdata = mregs[addr];
        wv = (m_rdata & ~mk) | (wd & mk);
        if (!abort) begin
          wr_q.push_back('{addr, wv});
          mregs[addr] = wv;
        end
      end
      3'd5: begin
        hit = 0; nr = 0; v = mregs[addr];
        for (int i = 1; i <= int'(PMAX); i++) begin
          v  = (f > 0 && i > f) ? v1 : mregs[addr];
          nr = i;
          if ((v & mk) == (wd & mk)) begin hit = 1; break; end
        end
        if (f > 0 && nr >= f) mregs[addr] = v1;
        m_rdata = v; e.nreads = nr; e.err = !hit; lat = 2 * nr;
      end
      default: begin lat = 1; e.err = 1; end
    endcase
    e.rdata   = m_rdata;
    e.done_at = acc + lat - 1;
    done_q.push_back(e);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running at 300000ns, expected to finish earlier");
    $fatal(1);
  end

  initial begin
    RESET = 1'b1; REQ = 1'b0; OP = 3'd0; ADDR = 2'd0; WDATA = 8'h00; MASK = 8'h00;
    flip_left = 0; flip_addr = 2'd0; flip_val = 8'h00;
    for (int i = 0; i < 4; i++) begin
      periph[i] = 8'h00;
      mregs[i]  = 8'h00;
    end
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_err", ERR, 0);
    check("rst_rdata", RDATA, 8'h00);
    check("rst_bus", {PPI_CS, PPI_WR, PPI_A, PPI_DOUT}, 0);

    issue(3'd0, 2'd3, 8'h80, 8'h00, 0, 8'h00, 0, 0);
    set_reg(2'd1, 8'h5A);
    issue(3'd1, 2'd1, 8'h00, 8'h00, 0, 8'h00, 0, 0);
    issue(3'd3, 2'd2, 8'h06, 8'h00, 0, 8'h00, 0, 0);
    issue(3'd2, 2'd0, 8'h07, 8'h00, 0, 8'h00, 0, 0);
    set_reg(2'd2, 8'hF0);
    issue(3'd4, 2'd2, 8'h05, 8'h0F, 0, 8'h00, 0, 0);
    set_reg(2'd0, 8'h00);
    issue(3'd5, 2'd0, 8'h01, 8'h01, 2, 8'h01, 0, 0);
    set_reg(2'd0, 8'h00);
    issue(3'd5, 2'd0, 8'h01, 8'h01, 0, 8'h00, 0, 0);
    issue(3'd5, 2'd1, 8'hFF, 8'h00, 0, 8'h00, 0, 0);
    issue(3'd6, 2'd1, 8'h12, 8'h34, 0, 8'h00, 0, 0);
    issue(3'd7, 2'd2, 8'h56, 8'h78, 0, 8'h00, 0, 0);

    // REQ held high through a whole command: ignored while busy, accepted right after DONE.
    issue(3'd0, 2'd1, 8'h11, 8'h00, 0, 8'h00, 1, 0);
    issue(3'd1, 2'd1, 8'h00, 8'h00, 0, 8'h00, 0, 0);

    // Reset during the GAP of an RMW: no write, no DONE, then a normal READ.
    set_reg(2'd2, 8'hC3);
    issue(3'd4, 2'd2, 8'h55, 8'h0F, 0, 8'h00, 0, 1);
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK);
    #1 RESET = 1'b0;
    done_q.delete();
    m_rdata = 8'h00;
    @(negedge CLK);
    check("abort_busy", BUSY, 0);
    check("abort_done", DONE, 0);
    check("abort_bus", {PPI_CS, PPI_WR, PPI_A, PPI_DOUT}, 0);
    check("abort_rdata", RDATA, 8'h00);
    issue(3'd1, 2'd2, 8'h00, 8'h00, 0, 8'h00, 0, 0);

    for (int n = 0; n < 80; n++) begin
      logic [2:0] op;
      logic [1:0] a;
      logic [7:0] wd, mk, v1;
      int f;
      op = 3'($urandom_range(0, 7));
      a  = 2'($urandom_range(0, 3));
      wd = 8'($urandom);
      mk = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      f  = (op == 3'd5) ? $urandom_range(0, 5) : 0;
      v1 = ($urandom_range(0, 1) == 1) ? ((8'($urandom) & ~mk) | (wd & mk)) : 8'($urandom);
      if ($urandom_range(0, 4) == 0) set_reg(a, 8'($urandom));
      issue(op, a, wd, mk, f, v1, 0, 0);
    end

    wait_idle();
    repeat (4) @(negedge CLK);
    check("done_queue_empty", done_q.size(), 0);
    check("write_queue_empty", wr_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ppi_host.md
PPI_HOST -- requirements
Module: ppi_host

Interface
REQ-001 SHALL provide parameter POLL_MAX, default 16'd255, meaning maximum number of read strobes in one POLL command (legal range 1..65535).
REQ-002 SHALL provide ports: CLK  in  1  single clock, all logic on rising edge.
REQ-003 SHALL provide RESET  in  1  reset, synchronous, active-high.
REQ-004 SHALL provide REQ  in  1  command request, sampled only while BUSY=0.
REQ-005 SHALL provide OP  in  3  000 WRITE, 001 READ, 010 BSET, 011 BCLR, 100 RMW, 101 POLL, 110/111 illegal.
REQ-006 SHALL provide ADDR  in  2  register select: 0 port A, 1 port B, 2 port C, 3 control.
REQ-007 SHALL provide WDATA  in  8  write data, bit index (BSET/BCLR, bits 2:0), or compare value (POLL).
REQ-008 SHALL provide MASK  in  8  bit mask for RMW and POLL.
REQ-009 SHALL provide BUSY  out  1  command in progress; RDATA  out  8  last captured read data; DONE  out  1  one-cycle completion pulse; ERR  out  1  error flag, valid while DONE=1.
REQ-010 SHALL provide PPI_CS  out  1, PPI_WR  out  1, PPI_A  out  2, PPI_DOUT  out  8 (to peripheral data input), PPI_DIN  in  8 (peripheral read data, combinational from CS/A).

Function
REQ-011 SHALL register all outputs; the idle bus state is PPI_CS=0, PPI_WR=0, PPI_A=00, PPI_DOUT=00.
REQ-012 SHALL latch OP/ADDR/WDATA/MASK at the edge where REQ=1 and BUSY=0 (acceptance edge k); BUSY=1 from cycle k+1 through the DONE cycle inclusive.
REQ-013 SHALL ignore REQ while BUSY=1; a REQ held high in the cycle after DONE is accepted as a new command.
REQ-014 SHALL implement states IDLE, RD, GAP, WR, FIN; FIN drives DONE=1 for exactly one cycle, then returns to IDLE.
REQ-015 Write strobe (state WR): one cycle of PPI_CS=1, PPI_WR=1, PPI_A=target, PPI_DOUT=data.
REQ-016 Read strobe (state RD): one cycle of PPI_CS=1, PPI_WR=0, PPI_A=ADDR; RDATA <= PPI_DIN at the end of that cycle.
REQ-017 Consecutive strobes within one command SHALL be separated by exactly one GAP cycle with the bus in the idle state.
REQ-018 WRITE: IDLE -> WR -> FIN; DONE in cycle k+2.
REQ-019 READ: IDLE -> RD -> FIN; DONE in cycle k+2 with RDATA already updated.
REQ-020 BSET/BCLR: single write strobe to ADDR 3 with PPI_DOUT = {4'b0000, WDATA[2:0], 1} for BSET and {4'b0000, WDATA[2:0], 0} for BCLR; latched ADDR is ignored.
REQ-021 RMW: RD -> GAP -> WR -> FIN; written value = (RDATA & ~MASK) | (WDATA & MASK) to ADDR; DONE in cycle k+4.
REQ-022 POLL: RD, then if (RDATA & MASK) == (WDATA & MASK) -> FIN with ERR=0, else GAP -> RD; if POLL_MAX reads complete without a match -> FIN with ERR=1.
REQ-023 POLL read counter SHALL be 16-bit, cleared at acceptance, saturating; MASK=00 matches on the first read.
REQ-024 Illegal OP: IDLE -> FIN with no bus strobe, ERR=1, RDATA unchanged.
REQ-025 ERR SHALL be 0 whenever DONE=0.
REQ-026 RDATA SHALL change only at the end of a RD cycle and hold otherwise, including across commands.

Reset
REQ-027 With RESET=1 at an edge: state <= IDLE, BUSY=0, DONE=0, ERR=0, RDATA=00, bus idle, POLL counter=0; takes priority over REQ.
REQ-028 Reset mid-command SHALL abort with no DONE pulse; the bus is idle in the cycle after the reset edge, and no partial RMW write is issued.

Verification
REQ-029 WRITE ADDR=3 WDATA=80 -> cycle k+1: CS=1 WR=1 A=3 DOUT=80; DONE=1 ERR=0 in cycle k+2; BUSY low in k+3.
REQ-030 READ ADDR=1 with PPI_DIN=5A -> CS=1 WR=0 A=1 in k+1; RDATA=5A and DONE=1 in k+2.
REQ-031 BCLR WDATA=06 -> single strobe A=3 DOUT=0C; BSET WDATA=07 -> DOUT=0F.
REQ-032 RMW ADDR=2, PPI_DIN=F0, MASK=0F, WDATA=05 -> read k+1, idle k+2, write DOUT=F5 A=2 in k+3, DONE in k+4.
REQ-033 POLL MASK=01 WDATA=01 POLL_MAX=4: PPI_DIN bit0 set before the 3rd read -> 3 reads, DONE ERR=0; never set -> exactly 4 reads, DONE ERR=1.
REQ-034 RESET asserted during the GAP of an RMW -> no write strobe, no DONE, BUSY=0 next cycle; a following READ completes normally.
